// File: rtl/agu_arbiter_if.sv
// Shared packet types plus the bundle of request, issue and writeback
// signals between the reservation stations, the AGU and the arbiter.
package agu_arbiter_pkg;
  localparam int TAG_WIDTH = 4;

  typedef struct packed {
    logic [TAG_WIDTH-1:0] dest_tag;
    logic [3:0]           opcode;
    logic [15:0]          imm;
  } instruction_t;

  typedef struct packed {
    logic                 is_valid;
    logic [TAG_WIDTH-1:0] dest_tag;
    logic [31:0]          data;
  } writeback_packet_t;
endpackage

interface agu_arbiter_if;
  import agu_arbiter_pkg::*;

  // Handshake: a requester holds req high until its own result returns on
  // its agu_port; grant pulses for exactly the cycle the packet is issued.
  logic                 flush;
  logic                 cache_stall;
  logic [TAG_WIDTH-1:0] rob_head;
  logic                 ld_req;
  instruction_t         ld_pkt;
  logic                 ld_grant;
  logic                 st_req;
  instruction_t         st_pkt;
  logic                 st_grant;
  logic                 agu_stall;
  logic                 agu_issue_valid;
  instruction_t         agu_issue_pkt;
  writeback_packet_t    agu_result;
  writeback_packet_t    ld_agu_port;
  writeback_packet_t    st_agu_port;
  logic                 agu_busy;

  modport slave (
    input  flush, cache_stall, rob_head, ld_req, ld_pkt, st_req, st_pkt,
           agu_stall, agu_result,
    output ld_grant, st_grant, agu_issue_valid, agu_issue_pkt,
           ld_agu_port, st_agu_port, agu_busy
  );

  modport master (
    output flush, cache_stall, rob_head, ld_req, ld_pkt, st_req, st_pkt,
           agu_stall, agu_result,
    input  ld_grant, st_grant, agu_issue_valid, agu_issue_pkt,
           ld_agu_port, st_agu_port, agu_busy
  );
endinterface

// File: rtl/agu_arbiter.sv
// Shares one AGU between the load and store reservation stations, tracks the
// owner of each in-flight op and routes results back, dropping flushed ones.
module agu_arbiter
  import agu_arbiter_pkg::*;
#(
  parameter int MAX_INFLIGHT = 2,
  parameter int CNT_W        = 2
) (
  input logic          clk,
  input logic          rst,
  agu_arbiter_if.slave bus
);

  // Owner FIFO is a shift register: bit 0 is the oldest op (0 = LD, 1 = ST).
  logic [MAX_INFLIGHT-1:0] fifo_q, fifo_d;
  logic [CNT_W-1:0]        occ_q, occ_d;
  logic [CNT_W-1:0]        drop_q, drop_d;
  logic                    busy_ld_q, busy_ld_d;
  logic                    busy_st_q, busy_st_d;
  logic                    rr_q, rr_d;

  logic             elig_ld, elig_st, hit_ld, hit_st;
  logic             res_v, pop, can_issue, grant, win_st;
  logic [CNT_W-1:0] occ_after_pop;

  always_comb begin
    elig_ld       = bus.ld_req & ~busy_ld_q;
    elig_st       = bus.st_req & ~busy_st_q;
    hit_ld        = elig_ld & (bus.ld_pkt.dest_tag == bus.rob_head);
    hit_st        = elig_st & (bus.st_pkt.dest_tag == bus.rob_head);
    res_v         = bus.agu_result.is_valid;
    pop           = res_v & ~bus.flush & (drop_q == '0) & (occ_q != '0);
    occ_after_pop = occ_q - CNT_W'(pop);
    can_issue     = ~bus.flush & ~bus.cache_stall & ~bus.agu_stall &
                    (drop_q == '0) & (occ_after_pop < CNT_W'(MAX_INFLIGHT));

    // The ROB-head match beats everything; a tie falls through to rr.
    if (hit_ld != hit_st)       win_st = hit_st;
    else if (elig_ld != elig_st) win_st = elig_st;
    else                         win_st = rr_q;
    grant = can_issue & (elig_ld | elig_st);

    bus.ld_grant        = grant & ~win_st;
    bus.st_grant        = grant & win_st;
    bus.agu_issue_valid = grant;
    bus.agu_issue_pkt   = '0;
    if (grant) bus.agu_issue_pkt = win_st ? bus.st_pkt : bus.ld_pkt;

    bus.ld_agu_port = '0;
    bus.st_agu_port = '0;
    if (pop) begin
      if (fifo_q[0]) bus.st_agu_port = bus.agu_result;
      else           bus.ld_agu_port = bus.agu_result;
    end
    bus.agu_busy = (occ_q != '0) | (drop_q != '0);
  end

  always_comb begin
    fifo_d    = fifo_q;
    occ_d     = occ_q;
    drop_d    = drop_q;
    busy_ld_d = busy_ld_q;
    busy_st_d = busy_st_q;
    rr_d      = rr_q;
    if (bus.flush) begin
      // Everything outstanding becomes a drop; a result landing now uses one up.
      fifo_d    = '0;
      occ_d     = '0;
      busy_ld_d = 1'b0;
      busy_st_d = 1'b0;
      drop_d    = drop_q + occ_q -
                  CNT_W'(res_v & ((drop_q != '0) | (occ_q != '0)));
    end else begin
      if (res_v && drop_q != '0) drop_d = drop_q - CNT_W'(1);
      if (pop) begin
        fifo_d = fifo_q >> 1;
        if (fifo_q[0]) busy_st_d = 1'b0;
        else           busy_ld_d = 1'b0;
      end
      if (grant) begin
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
          if (occ_after_pop == CNT_W'(i)) fifo_d[i] = win_st;
        end
        if (win_st) busy_st_d = 1'b1;
        else        busy_ld_d = 1'b1;
        rr_d = ~win_st;
      end
      occ_d = occ_after_pop + CNT_W'(grant);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q    <= '0;
      occ_q     <= '0;
      drop_q    <= '0;
      busy_ld_q <= 1'b0;
      busy_st_q <= 1'b0;
      rr_q      <= 1'b0;
    end else begin
      fifo_q    <= fifo_d;
      occ_q     <= occ_d;
      drop_q    <= drop_d;
      busy_ld_q <= busy_ld_d;
      busy_st_q <= busy_st_d;
      rr_q      <= rr_d;
    end
  end

endmodule

// File: tb/tb_agu_arbiter.sv
// Directed scenarios followed by random traffic, every cycle checked against
// a queue-based model of owners, busy flags, drops and a fixed-latency AGU.
module tb_agu_arbiter;
  import agu_arbiter_pkg::*;

  localparam int MAXI = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  agu_arbiter_if bus ();
  agu_arbiter #(.MAX_INFLIGHT(MAXI), .CNT_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // stimulus
  bit                   s_rst, s_flush, s_cstall, s_astall, s_ld_req, s_st_req, s_spur;
  instruction_t         s_ld_pkt, s_st_pkt;
  logic [TAG_WIDTH-1:0] s_head;

  // reference model
  int  own_q[$];
  int  drop;
  bit  busy[2];
  int  rr;
  writeback_packet_t res_q[$];
  int  due_q[$];
  int  lat;
  int  cyc;
  int  last_due;

  // observations from the most recent checked cycle
  bit                seen_ldg, seen_stg, seen_iv, seen_busy;
  writeback_packet_t seen_ldp, seen_stp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    writeback_packet_t res, e_ldp, e_stp;
    instruction_t      e_pkt;
    bit from_pipe, pop, ok, g, hit0, hit1;
    bit el[2];
    int w, occ, o, d, due;
    @(negedge clk);
    res = '0;
    from_pipe = 1'b0;
    g = 1'b0;
    w = 0;
    if (!s_rst && due_q.size() > 0 && due_q[0] == cyc) begin
      res = res_q[0];
      from_pipe = 1'b1;
    end else if (!s_rst && s_spur && due_q.size() == 0) begin
      res.is_valid = 1'b1;
      res.dest_tag = TAG_WIDTH'($urandom_range(0, 15));
      res.data     = $urandom;
    end
    rst             = s_rst;
    bus.flush       = s_flush;
    bus.cache_stall = s_cstall;
    bus.agu_stall   = s_astall;
    bus.rob_head    = s_head;
    bus.ld_req      = s_ld_req;
    bus.ld_pkt      = s_ld_pkt;
    bus.st_req      = s_st_req;
    bus.st_pkt      = s_st_pkt;
    bus.agu_result  = res;
    #1;
    if (!s_rst) begin
      occ = own_q.size();
      pop = res.is_valid && !s_flush && drop == 0 && occ > 0;
      ok  = !s_flush && !s_cstall && !s_astall && drop == 0 &&
            (occ - (pop ? 1 : 0)) < MAXI;
      el[0] = s_ld_req && !busy[0];
      el[1] = s_st_req && !busy[1];
      hit0  = el[0] && (s_ld_pkt.dest_tag == s_head);
      hit1  = el[1] && (s_st_pkt.dest_tag == s_head);
      if (hit0 != hit1)        w = hit1 ? 1 : 0;
      else if (el[0] != el[1]) w = el[1] ? 1 : 0;
      else                     w = rr;
      g = ok && (el[0] || el[1]);
      e_pkt = '0;
      if (g) e_pkt = (w == 1) ? s_st_pkt : s_ld_pkt;
      e_ldp = '0;
      e_stp = '0;
      if (pop) begin
        if (own_q[0] == 1) e_stp = res;
        else               e_ldp = res;
      end
      chk("ld_grant", 64'(bus.ld_grant), 64'(g && w == 0));
      chk("st_grant", 64'(bus.st_grant), 64'(g && w == 1));
      chk("issue_valid", 64'(bus.agu_issue_valid), 64'(g));
      chk("issue_pkt", 64'(bus.agu_issue_pkt), 64'(e_pkt));
      chk("ld_port", 64'(bus.ld_agu_port), 64'(e_ldp));
      chk("st_port", 64'(bus.st_agu_port), 64'(e_stp));
      chk("agu_busy", 64'(bus.agu_busy), 64'(occ > 0 || drop > 0));
      seen_ldg  = bus.ld_grant;
      seen_stg  = bus.st_grant;
      seen_iv   = bus.agu_issue_valid;
      seen_busy = bus.agu_busy;
      seen_ldp  = bus.ld_agu_port;
      seen_stp  = bus.st_agu_port;
    end
    @(posedge clk);
    if (s_rst) begin
      own_q.delete();
      res_q.delete();
      due_q.delete();
      drop = 0;
      busy = '{0, 0};
      rr = 0;
      last_due = cyc;
    end else begin
      if (from_pipe) begin
        void'(res_q.pop_front());
        void'(due_q.pop_front());
      end
      if (s_flush) begin
        d = drop + own_q.size() - (res.is_valid ? 1 : 0);
        drop = (d < 0) ? 0 : d;
        own_q.delete();
        busy = '{0, 0};
      end else begin
        if (res.is_valid) begin
          if (drop > 0) drop--;
          else if (own_q.size() > 0) begin
            o = own_q.pop_front();
            busy[o] = 1'b0;
          end
        end
        if (g) begin
          own_q.push_back(w);
          busy[w] = 1'b1;
          rr = 1 - w;
          due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
          last_due = due;
          due_q.push_back(due);
          res_q.push_back('{is_valid: 1'b1, dest_tag: e_pkt.dest_tag, data: $urandom});
        end
      end
    end
    cyc++;
  endtask

  task automatic idle_inputs();
    s_rst = 0; s_flush = 0; s_cstall = 0; s_astall = 0; s_spur = 0;
    s_ld_req = 0; s_st_req = 0;
    s_ld_pkt = '{dest_tag: 4'd1, opcode: 4'h3, imm: 16'h1111};
    s_st_pkt = '{dest_tag: 4'd2, opcode: 4'h7, imm: 16'h2222};
    s_head = 4'd9;
  endtask

  task automatic drain(input int n);
    s_ld_req = 0; s_st_req = 0;
    repeat (n) tick();
  endtask

  initial begin
    cyc = 0; lat = 1; last_due = 0; drop = 0; rr = 0; busy = '{0, 0};
    idle_inputs();
    s_rst = 1;
    repeat (2) tick();
    s_rst = 0;
    tick();
    chk("reset_busy", 64'(seen_busy), 64'(0));
    chk("reset_iv", 64'(seen_iv), 64'(0));

    // Both request, latency 1: LD first, then ST while LD's result returns.
    lat = 1; s_ld_req = 1; s_st_req = 1;
    tick();
    chk("tp1_c0_ldg", 64'(seen_ldg), 64'(1));
    tick();
    chk("tp1_c1_ldport", 64'(seen_ldp.is_valid), 64'(1));
    chk("tp1_c1_stg", 64'(seen_stg), 64'(1));
    s_ld_req = 0; s_st_req = 0;
    tick();
    chk("tp1_c2_stport", 64'(seen_stp.is_valid), 64'(1));
    drain(2);

    // ST at the ROB head beats rr preferring LD.
    s_st_pkt.dest_tag = 4'd5; s_head = 4'd5;
    s_ld_req = 1; s_st_req = 1;
    tick();
    chk("tp2_stg", 64'(seen_stg), 64'(1));
    tick();
    chk("tp2_ldg", 64'(seen_ldg), 64'(1));
    drain(3);
    s_head = 4'd9;

    // Latency 3: two grants fill the FIFO, third blocked.
    lat = 3; s_ld_req = 1; s_st_req = 1;
    repeat (2) tick();
    tick();
    chk("tp3_full_block", 64'(seen_iv), 64'(0));
    repeat (6) tick();
    drain(5);

    // Flush with two in flight: both results dropped, busy throughout.
    s_ld_req = 1; s_st_req = 1;
    repeat (2) tick();
    s_flush = 1;
    tick();
    s_flush = 0;
    tick();
    chk("tp4_busy", 64'(seen_busy), 64'(1));
    chk("tp4_no_issue", 64'(seen_iv), 64'(0));
    repeat (3) tick();
    drain(4);

    // ST held high with agu_stall toggling.
    lat = 2; s_st_req = 1;
    for (int i = 0; i < 8; i++) begin
      s_astall = i[0];
      tick();
    end
    s_astall = 0;
    drain(4);

    // Spurious result, then reset with ops in flight.
    s_spur = 1;
    tick();
    chk("tp6_spur_ld", 64'(seen_ldp), 64'(0));
    chk("tp6_spur_st", 64'(seen_stp), 64'(0));
    s_spur = 0;
    lat = 3; s_ld_req = 1; s_st_req = 1;
    repeat (2) tick();
    s_rst = 1; s_ld_req = 0; s_st_req = 0;
    tick();
    s_rst = 0;
    tick();
    chk("tp6_rst_busy", 64'(seen_busy), 64'(0));

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      s_rst    = ($urandom_range(0, 199) == 0);
      s_flush  = ($urandom_range(0, 19) == 0);
      s_cstall = ($urandom_range(0, 7) == 0);
      s_astall = ($urandom_range(0, 4) == 0);
      s_spur   = ($urandom_range(0, 9) == 0);
      s_ld_req = ($urandom_range(0, 3) != 0);
      s_st_req = ($urandom_range(0, 3) != 0);
      s_ld_pkt = '{dest_tag: TAG_WIDTH'($urandom_range(0, 3)), opcode: 4'($urandom), imm: 16'($urandom)};
      s_st_pkt = '{dest_tag: TAG_WIDTH'($urandom_range(0, 3)), opcode: 4'($urandom), imm: 16'($urandom)};
      s_head   = TAG_WIDTH'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) lat = $urandom_range(1, 4);
      tick();
    end
    idle_inputs();
    drain(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/agu_arbiter.md
Name: agu_arbiter

Overview:
- Shares the single address-generation unit (AGU) between the load reservation station (requester 0, LD) and the store reservation station (requester 1, ST).
- Selects one ready requester per cycle and issues its packet to the AGU.
- Records the owner of each in-flight operation and routes each AGU result back only to that owner.
- Discards results that belong to operations killed by a flush.

Parameters:
- MAX_INFLIGHT, 2: depth of the in-order owner FIFO; this is the maximum number of AGU operations outstanding at once.
- CNT_W, 2: width of the occupancy and drop counters; must satisfy 2**CNT_W > MAX_INFLIGHT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush (mispredict/exception)
- cache_stall  in  1  global freeze; no new issue
- rob_head  in  TAG_WIDTH  tag of the oldest ROB entry
- ld_req  in  1  load RS has a packet ready for the AGU
- ld_pkt  in  instruction_t  load RS packet
- ld_grant  out  1  load packet issued this cycle
- st_req  in  1  store RS ready for the AGU (its agu_read_rdy)
- st_pkt  in  instruction_t  store RS packet
- st_grant  out  1  store packet issued this cycle
- agu_stall  in  1  AGU cannot accept this cycle
- agu_issue_valid  out  1  issue strobe to the AGU
- agu_issue_pkt  out  instruction_t  packet being issued
- agu_result  in  writeback_packet_t  AGU output; returns in issue order
- ld_agu_port  out  writeback_packet_t  routed result for the load RS
- st_agu_port  out  writeback_packet_t  routed result for the store RS
- agu_busy  out  1  owner FIFO non-empty or drop count non-zero

Behaviour:
- State elements:
  - owner FIFO: MAX_INFLIGHT entries, 1 bit each (0 = LD, 1 = ST).
  - occ: FIFO occupancy.
  - busy_ld, busy_st: per-requester pending bits.
  - rr: round-robin pointer; value is the preferred requester.
  - drop_cnt: number of returning results to discard.
- Reset: FIFO empty, occ = 0, busy bits = 0, rr = 0 (LD preferred), drop_cnt = 0.
- Outputs at reset: all grants 0, agu_issue_valid = 0, both routed ports all-zero, agu_busy = 0.
- Eligibility: elig_ld = ld_req & !busy_ld; elig_st = st_req & !busy_st. A requester keeps its request high until its own result returns; the busy bit masks that request so it is never granted twice.
- Issue allowed when: !flush & !cache_stall & !agu_stall & occ < MAX_INFLIGHT & drop_cnt == 0. An issue in the same cycle as a pop counts as if the pop happens first.
- Selection (combinational, zero latency from request to grant), in priority order:
  1. An eligible requester whose pkt.dest_tag == rob_head wins (oldest-first, avoids deadlock at commit).
  2. Otherwise, if exactly one requester is eligible, it wins.
  3. Otherwise rr decides.
- On grant:
  - the grant output of the winner pulses 1;
  - agu_issue_valid = 1 and agu_issue_pkt = the winner's packet, otherwise '0;
  - the owner bit is pushed into the FIFO;
  - the winner's busy bit is set;
  - rr <= the non-winner.
- Result handling, when agu_result.is_valid:
  - If drop_cnt > 0: drop_cnt decrements and both routed ports stay zero.
  - Else if occ > 0: the FIFO head is popped; the owner's port = agu_result with is_valid = 1, the other port = '0; the owner's busy bit clears on the next edge.
  - Else (spurious result): ignored; no state change.
- Routed ports are combinational from agu_result, with zero latency, so the store RS sees its agu_port result in the same cycle.
- Simultaneous pop and push: occ is unchanged and both take effect. The same requester may be re-granted only after its busy bit has cleared, which is the next cycle at the earliest.
- flush (highest priority after rst):
  - no grant; both routed ports are forced to zero;
  - FIFO and busy bits clear; rr is unchanged;
  - drop_cnt <= occ − (agu_result.is_valid ? 1 : 0); a result arriving in the flush cycle is itself discarded.
  - If flush arrives while drop_cnt > 0, it is additive: drop_cnt <= drop_cnt + occ − (result in this cycle ? 1 : 0).
- cache_stall blocks new grants only; in-flight results are still routed and dropped normally.
- Mid-operation rst clears everything, including drop_cnt. The AGU is reset by the same rst, so no stale results are expected.

Test Plan:
- ld_req = st_req = 1, rr = 0, neither tag at rob_head, AGU latency 1 → cycle 0: ld_grant = 1 with owner LD. Cycle 1: the LD result routes to ld_agu_port and st is granted. Cycle 2: the result routes to st_agu_port.
- st_pkt.dest_tag = 5 = rob_head, both requesting, rr = 0 → st_grant = 1 first and ld waits one cycle; rr becomes 0 after the ST grant.
- MAX_INFLIGHT = 2, AGU latency 3, two back-to-back grants → third grant blocked (occ = 2) until the first result pops; the pop and a new push in the same cycle leave occ = 2.
- Two ops in flight, flush asserted with no result that cycle → drop_cnt = 2. The next two results appear on neither port, no grant is issued until drop_cnt = 0, and agu_busy = 1 throughout.
- st_req held high while its op is in flight with agu_stall toggling → exactly one st_grant; the result clears busy_st and st is re-grantable the following cycle.
- agu_result.is_valid = 1 with occ = 0 and drop_cnt = 0 → both ports zero and no state change; rst mid-flight → all outputs 0 next cycle.
